// File: rtl/branch_predictor.sv
// branch_predictor: bimodal 2-bit counter predictor with registered redirect.
// Optional gshare indexing when BP_GSHARE_EN is defined.
module branch_predictor #(
    parameter int IDX_W  = 4,
    parameter int PC_W   = 32,
    parameter int HIST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [5:0]      ex_opcode,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic            ex_pred,
    input  logic [PC_W-1:0] ex_target,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_q [DEPTH];
    logic [1:0]       cnt_d [DEPTH];
    logic [1:0]       cnt_cur;
    logic             upd;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             redirect_valid_q;
    logic             redirect_valid_d;
    logic [PC_W-1:0]  redirect_pc_q;
    logic [PC_W-1:0]  redirect_pc_d;
    logic             unused_pc;

    assign upd = ex_valid & (ex_opcode == 6'h04 | ex_opcode == 6'h05);

    assign unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;

    assign pred_idx = if_pc[IDX_W+1:2] ^ IDX_W'(hist_q);
    assign upd_idx  = ex_pc[IDX_W+1:2] ^ IDX_W'(hist_q);

    // Shift each resolved branch outcome into the global history.
    always_comb begin
        hist_d = hist_q;
        if (upd) begin
            hist_d = {hist_q[HIST_W-2:0], ex_taken};
        end
    end

    // History register, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    localparam int unused_hist_w = HIST_W;

    assign pred_idx = if_pc[IDX_W+1:2];
    assign upd_idx  = ex_pc[IDX_W+1:2];
`endif

    // Read-before-write: prediction always comes from the registered table.
    assign pred_taken     = cnt_q[pred_idx][1];
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    // Saturating counter step for the resolved branch's entry.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_cur = cnt_q[upd_idx];
        if (upd) begin
            if (ex_taken && cnt_cur != 2'b11) begin
                cnt_d[upd_idx] = cnt_cur + 2'd1;
            end else if (!ex_taken && cnt_cur != 2'b00) begin
                cnt_d[upd_idx] = cnt_cur - 2'd1;
            end
        end
    end

    // Mispredict detection; the address only moves when a redirect fires.
    always_comb begin
        redirect_valid_d = upd & (ex_taken != ex_pred);
        redirect_pc_d    = redirect_pc_q;
        if (redirect_valid_d) begin
            redirect_pc_d = ex_taken ? ex_target : ex_pc + PC_W'(4);
        end
    end

    // Counter table and redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= 2'b01;
            end
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors for branch_predictor.
// Gshare-specific vectors run when BP_GSHARE_EN is defined.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp;
    int n_bad;

    branch_predictor #(
        .IDX_W (4),
        .PC_W  (32),
        .HIST_W(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_pred       (ex_pred),
        .ex_target     (ex_target),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ex_drive(input logic v, input logic [5:0] op,
                            input logic [31:0] pc, input logic tk,
                            input logic pr, input logic [31:0] tg);
        ex_valid  = v;
        ex_opcode = op;
        ex_pc     = pc;
        ex_taken  = tk;
        ex_pred   = pr;
        ex_target = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        if_pc = 32'h10;
        ex_drive(1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_pred", 32'(pred_taken), 0);
        check("rst_rv", 32'(redirect_valid), 0);
        check("rst_rpc", redirect_pc, 0);
        rst_n = 1'b1;
        tick();

`ifdef BP_GSHARE_EN
        // idx 4 (hist 0) then idx 5 (hist 1); hist ends at 4'b0011
        ex_drive(1'b1, 6'h04, 32'h10, 1'b1, 1'b0, 32'h40);
        tick();
        check("gs_rv1", 32'(redirect_valid), 1);
        check("gs_rpc1", redirect_pc, 32'h40);
        ex_drive(1'b0, 6'h04, 32'h10, 1'b1, 1'b0, 32'h40);
        if_pc = 32'h14;
        #1;
        check("gs_h1_0x14", 32'(pred_taken), 1);
        ex_drive(1'b1, 6'h04, 32'h10, 1'b1, 1'b0, 32'h44);
        tick();
        ex_drive(1'b0, 6'h04, 32'h10, 1'b1, 1'b0, 32'h44);
        check("gs_rpc2", redirect_pc, 32'h44);
        if_pc = 32'h10;
        #1;
        check("gs_h3_0x10", 32'(pred_taken), 0);
        if_pc = 32'h1C;
        #1;
        check("gs_h3_0x1c", 32'(pred_taken), 1);
        if_pc = 32'h14;
        #1;
        check("gs_h3_0x14", 32'(pred_taken), 0);
        tick();
        check("gs_rv_idle", 32'(redirect_valid), 0);
`else
        // three taken updates at 0x10: 01->10->11->11
        ex_drive(1'b1, 6'h04, 32'h10, 1'b1, 1'b0, 32'h40);
        #3;
        check("sat_pre", 32'(pred_taken), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_pred", 32'(pred_taken), 1);
            check("sat_rv", 32'(redirect_valid), 1);
            check("sat_rpc", redirect_pc, 32'h40);
        end
        ex_drive(1'b0, 6'h04, 32'h10, 1'b1, 1'b0, 32'h40);
        tick();
        check("idle_rv", 32'(redirect_valid), 0);
        check("idle_rpc_hold", redirect_pc, 32'h40);
        check("idle_pred", 32'(pred_taken), 1);

        // one not-taken step from saturated 11 -> 10
        ex_drive(1'b1, 6'h04, 32'h10, 1'b0, 1'b1, 32'h40);
        tick();
        check("dec_pred", 32'(pred_taken), 1);
        check("dec_rv", 32'(redirect_valid), 1);
        check("dec_rpc", redirect_pc, 32'h14);

        // BNE not-taken at 0x20: 01->00
        if_pc = 32'h20;
        ex_drive(1'b1, 6'h05, 32'h20, 1'b0, 1'b1, 32'h99);
        #3;
        check("bne_pre", 32'(pred_taken), 0);
        tick();
        check("bne_rv", 32'(redirect_valid), 1);
        check("bne_rpc", redirect_pc, 32'h24);
        check("bne_pred", 32'(pred_taken), 0);

        // taken from 00 -> 01, still predicts not-taken
        ex_drive(1'b1, 6'h04, 32'h20, 1'b1, 1'b0, 32'h80);
        tick();
        check("up00_pred", 32'(pred_taken), 0);
        check("up00_rv", 32'(redirect_valid), 1);
        check("up00_rpc", redirect_pc, 32'h80);

        // LW is not a conditional branch
        ex_drive(1'b1, 6'h23, 32'h20, 1'b1, 1'b0, 32'hAA);
        tick();
        check("lw_rv", 32'(redirect_valid), 0);
        check("lw_rpc", redirect_pc, 32'h80);
        check("lw_pred", 32'(pred_taken), 0);

        // ex_valid low with a branch opcode
        ex_drive(1'b0, 6'h04, 32'h20, 1'b1, 1'b0, 32'hBB);
        tick();
        check("nv_rv", 32'(redirect_valid), 0);
        check("nv_pred", 32'(pred_taken), 0);

        // correct prediction trains but does not redirect: 01->10
        ex_drive(1'b1, 6'h04, 32'h20, 1'b1, 1'b1, 32'hCC);
        tick();
        check("ok_rv", 32'(redirect_valid), 0);
        check("ok_rpc", redirect_pc, 32'h80);
        check("ok_pred", 32'(pred_taken), 1);

        // read/write collision at 0x30
        if_pc = 32'h30;
        ex_drive(1'b1, 6'h04, 32'h30, 1'b1, 1'b0, 32'h50);
        #3;
        check("col_pre", 32'(pred_taken), 0);
        tick();
        check("col_post", 32'(pred_taken), 1);
        check("col_rpc", redirect_pc, 32'h50);

        // fall-through address wraps
        ex_drive(1'b1, 6'h05, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
        tick();
        check("wrap_rv", 32'(redirect_valid), 1);
        check("wrap_rpc", redirect_pc, 32'h0);
        ex_drive(1'b0, 6'h05, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
        tick();
        check("pulse_rv", 32'(redirect_valid), 0);

        // reset right after a mispredict
        ex_drive(1'b1, 6'h04, 32'h30, 1'b1, 1'b0, 32'h60);
        tick();
        check("prerst_rv", 32'(redirect_valid), 1);
        check("prerst_pred", 32'(pred_taken), 1);
        rst_n = 1'b0;
        ex_drive(1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("mrst_rv", 32'(redirect_valid), 0);
        check("mrst_rpc", redirect_pc, 32'h0);
        check("mrst_pred", 32'(pred_taken), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_rv", 32'(redirect_valid), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
